// File: rtl/i2s_tx.sv
// I2S transmitter: 16-bit samples in 32-bit slots, BCLK = 64*Fs, one-deep
// holding buffer that repeats on underrun and keeps the newest sample on overrun.
module i2s_tx #(
    parameter int CLK_RATE    = 24576000,
    parameter int AUDIO_RATE  = 48000,
    parameter int SAMPLE_BITS = 16,
    parameter int SLOT_BITS   = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   sample_ce,
    input  logic [SAMPLE_BITS-1:0] audio_l,
    input  logic [SAMPLE_BITS-1:0] audio_r,
    input  logic                   mute,
    output logic                   i2s_bclk,
    output logic                   i2s_lrclk,
    output logic                   i2s_sdata,
    output logic                   underrun,
    output logic                   overrun
);

    localparam int DIV   = CLK_RATE / (AUDIO_RATE * 2 * SLOT_BITS);
    localparam int FRAME = 2 * SLOT_BITS;
    localparam int CW    = $clog2(DIV);
    localparam int PW    = $clog2(FRAME);
    localparam int SW    = (SAMPLE_BITS > 1) ? $clog2(SAMPLE_BITS) : 1;

    if (DIV % 2 != 0 || DIV < 4) begin : g_bad_div
        $error("i2s_tx: derived DIV must be even and >= 4");
    end
    if (SLOT_BITS < SAMPLE_BITS) begin : g_bad_slot
        $error("i2s_tx: SLOT_BITS must be >= SAMPLE_BITS");
    end

    logic [CW-1:0]          cnt;
    logic [PW-1:0]          pos;
    logic [SAMPLE_BITS-1:0] hold_l, hold_r;
    logic [SAMPLE_BITS-1:0] last_l, last_r;
    logic [SAMPLE_BITS-1:0] shift_l, shift_r;
    logic                   pending;

    logic                   fall, load;
    logic [CW-1:0]          cnt_next;
    logic [PW-1:0]          pos_next;
    logic [SAMPLE_BITS-1:0] src_l, src_r;
    logic [SAMPLE_BITS-1:0] shift_l_next, shift_r_next;

    // Word select leads each slot's MSB by one bit period.
    function automatic logic lr_at(input logic [PW-1:0] p);
        int pi;
        pi = int'(p);
        return (pi >= SLOT_BITS - 1) && (pi <= 2 * SLOT_BITS - 2);
    endfunction

    function automatic logic bit_at(input logic [PW-1:0]          p,
                                    input logic [SAMPLE_BITS-1:0] sl,
                                    input logic [SAMPLE_BITS-1:0] sr);
        int            pi;
        logic [SW-1:0] k;
        logic          b;
        pi = int'(p);
        b  = 1'b0;
        if (pi < SAMPLE_BITS) begin
            k = SW'(SAMPLE_BITS - 1 - pi);
            b = sl[k];
        end else if (pi >= SLOT_BITS && pi < SLOT_BITS + SAMPLE_BITS) begin
            k = SW'(SAMPLE_BITS - 1 - (pi - SLOT_BITS));
            b = sr[k];
        end
        return b;
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        fall         = (cnt == CW'(DIV - 1));
        load         = fall && (pos == PW'(FRAME - 1));
        cnt_next     = fall ? '0 : cnt + CW'(1);
        pos_next     = (pos == PW'(FRAME - 1)) ? '0 : pos + PW'(1);
        src_l        = last_l;
        src_r        = last_r;
        if (sample_ce) begin
            src_l = audio_l;
            src_r = audio_r;
        end else if (pending) begin
            src_l = hold_l;
            src_r = hold_r;
        end
        shift_l_next = shift_l;
        shift_r_next = shift_r;
        if (load) begin
            shift_l_next = mute ? '0 : src_l;
            shift_r_next = mute ? '0 : src_r;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt       <= '0;
            pos       <= '0;
            hold_l    <= '0;
            hold_r    <= '0;
            last_l    <= '0;
            last_r    <= '0;
            shift_l   <= '0;
            shift_r   <= '0;
            pending   <= 1'b0;
            i2s_bclk  <= 1'b0;
            i2s_lrclk <= 1'b0;
            i2s_sdata <= 1'b0;
            underrun  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            cnt      <= cnt_next;
            i2s_bclk <= (cnt_next >= CW'(DIV / 2));
            underrun <= load && !pending && !sample_ce;
            overrun  <= sample_ce && pending && !load;

            // A strobe coinciding with the load bypasses the holding register.
            if (load) begin
                shift_l <= shift_l_next;
                shift_r <= shift_r_next;
                last_l  <= src_l;
                last_r  <= src_r;
                pending <= 1'b0;
            end else if (sample_ce) begin
                hold_l  <= audio_l;
                hold_r  <= audio_r;
                pending <= 1'b1;
            end

            if (fall) begin
                pos       <= pos_next;
                i2s_lrclk <= lr_at(pos_next);
                i2s_sdata <= bit_at(pos_next, shift_l_next, shift_r_next);
            end
        end
    end

endmodule

// File: tb/tb_i2s_tx.sv
// Directed bench for i2s_tx: frame-by-frame vector table plus a mid-frame reset sequence.
module tb_i2s_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic        sample_ce;
    logic [15:0] audio_l, audio_r;
    logic        mute;
    logic        i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun;

    int errors = 0;
    int checks = 0;

    localparam logic [63:0] LR_EXP = 64'h0000_0001_FFFF_FFFE;

    i2s_tx dut (
        .clk       (clk),
        .reset     (reset),
        .sample_ce (sample_ce),
        .audio_l   (audio_l),
        .audio_r   (audio_r),
        .mute      (mute),
        .i2s_bclk  (i2s_bclk),
        .i2s_lrclk (i2s_lrclk),
        .i2s_sdata (i2s_sdata),
        .underrun  (underrun),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          ce1;
        logic [15:0] l1, r1;
        int          ce2;
        logic [15:0] l2, r2;
        int          mute_at;
        logic        mute_val;
        logic [63:0] exp_sd;
        int          exp_und;
        int          exp_ovr;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mk(input logic [15:0] l, input logic [15:0] r);
        return {l, 16'h0000, r, 16'h0000};
    endfunction

    // One 512-clk frame window starting right after a load edge; offsets count posedges.
    task automatic run_frame(input vec_t v, output logic [63:0] sd, output logic [63:0] lr,
                             output int und, output int ovr, output int und_at,
                             output int bclk_err);
        sd = '0; lr = '0; und = 0; ovr = 0; und_at = -1; bclk_err = 0;
        for (int i = 1; i <= 512; i++) begin
            sample_ce = (i == v.ce1) || (i == v.ce2);
            if (i == v.ce2) begin
                audio_l = v.l2; audio_r = v.r2;
            end else begin
                audio_l = v.l1; audio_r = v.r1;
            end
            if (i == v.mute_at) mute = v.mute_val;
            @(negedge clk);
            if (i2s_bclk !== ((i % 8) >= 4)) bclk_err++;
            if (i % 8 == 4) begin
                sd[63 - (i / 8)] = i2s_sdata;
                lr[63 - (i / 8)] = i2s_lrclk;
            end
            if (underrun === 1'b1) begin
                und++;
                if (und_at < 0) und_at = i;
            end
            if (overrun === 1'b1) ovr++;
        end
        sample_ce = 1'b0;
    endtask

    task automatic run_vec(input int f);
        logic [63:0] sd, lr;
        int und, ovr, und_at, bclk_err;
        run_frame(vecs[f], sd, lr, und, ovr, und_at, bclk_err);
        check($sformatf("frame%0d_sdata", f), sd, vecs[f].exp_sd);
        check($sformatf("frame%0d_lrclk", f), lr, LR_EXP);
        check($sformatf("frame%0d_underrun", f), und, vecs[f].exp_und);
        check($sformatf("frame%0d_overrun", f), ovr, vecs[f].exp_ovr);
        check($sformatf("frame%0d_bclk_errs", f), bclk_err, 0);
        if (vecs[f].exp_und > 0) check($sformatf("frame%0d_underrun_cycle", f), und_at, 512);
    endtask

    initial begin
        //         ce1  l1        r1        ce2  l2        r2        mute  val   expected sdata              und ovr
        vecs[0]  = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, 64'h0,                      1, 0};
        vecs[1]  = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, 64'h0,                      1, 0};
        vecs[2]  = '{100, 16'hA5C3, 16'h8001, 0,   16'h0000, 16'h0000, 0,   1'b0, 64'h0,                      0, 0};
        vecs[3]  = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'hA5C3, 16'h8001),     1, 0};
        vecs[4]  = '{50,  16'h1234, 16'h5678, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'hA5C3, 16'h8001),     0, 0};
        vecs[5]  = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'h1234, 16'h5678),     1, 0};
        vecs[6]  = '{100, 16'h1111, 16'h0011, 300, 16'h2222, 16'h0022, 0,   1'b0, mk(16'h1234, 16'h5678),     0, 1};
        vecs[7]  = '{512, 16'h3333, 16'h0033, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'h2222, 16'h0022),     0, 0};
        vecs[8]  = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'h3333, 16'h0033),     1, 0};
        vecs[9]  = '{10,  16'h7FFF, 16'h8000, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'h3333, 16'h0033),     0, 0};
        vecs[10] = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 200, 1'b1, mk(16'h7FFF, 16'h8000),     1, 0};
        vecs[11] = '{200, 16'h4321, 16'hABCD, 0,   16'h0000, 16'h0000, 100, 1'b0, 64'h0,                      0, 0};
        vecs[12] = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, mk(16'h4321, 16'hABCD),     1, 0};
        vecs[13] = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, 64'h0,                      1, 0};
        vecs[14] = '{0,   16'h0000, 16'h0000, 0,   16'h0000, 16'h0000, 0,   1'b0, 64'h0,                      1, 0};

        reset = 1'b1; sample_ce = 1'b0; mute = 1'b0; audio_l = '0; audio_r = '0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {59'b0, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun}, 64'h0);
        reset = 1'b0;

        for (int f = 0; f <= 12; f++) run_vec(f);

        // Mid-frame reset at pos 20 with a sample pending; state must clear completely.
        for (int i = 1; i <= 165; i++) begin
            sample_ce = (i == 50);
            audio_l   = 16'h5555;
            audio_r   = 16'hAAAA;
            @(negedge clk);
        end
        sample_ce = 1'b0;
        check("pre_reset_bclk_high", {63'b0, i2s_bclk}, 64'h1);
        reset = 1'b1;
        @(negedge clk);
        check("midframe_reset_outputs", {59'b0, i2s_bclk, i2s_lrclk, i2s_sdata, underrun, overrun}, 64'h0);
        reset = 1'b0;

        for (int f = 13; f <= 14; f++) run_vec(f);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
